fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl_pkg.sv | 17 +
 rtl/fetch_ctrl_if.sv | 17 +
 rtl/fetch_ctrl_if_buf.sv | 36 +++
 rtl/fetch_ctrl.sv | 113 +++++++++++
 tb/tb_fetch_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  localparam int WORD_WIDTH = 32;

  // prog_count next-address select and reset address
  localparam logic PC_JUMP    = 1'b1;
  localparam logic PC_INCRESE = 1'b0;
  localparam logic [WORD_WIDTH-1:0] PC_INIT = '0;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_FETCH = 2'd1,
    FETCH_KILL  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read port between fetch_ctrl (master) and the memory (slave).
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) ();
  // Handshake: req rises with addr and stays high until the cycle ack is high;
  // that cycle rdata is valid and the transfer completes (ack may come in the
  // same cycle req rises). At most one read is outstanding. A memory latches
  // addr when req rises: addr may retarget while a discarded read is in flight.
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [INST_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_ctrl_if_buf.sv
// One-entry IF/ID buffer: flush beats write, write beats consume.
module fetch_ctrl_if_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = WORD_WIDTH,
  parameter int INST_W = WORD_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              consume,
  input  logic              flush,
  input  logic [INST_W-1:0] wr_instr,
  input  logic [ADDR_W-1:0] wr_pc,
  output logic              valid,
  output logic [INST_W-1:0] instr,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (write) begin
      valid <= 1'b1;
      instr <= wr_instr;
      pc    <= wr_pc;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem read, one-entry IF/ID buffer,
// EX redirects with wrong-path discard. Optional counters under FETCH_PERF_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = WORD_WIDTH,
  parameter int INST_W = WORD_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_stall,
  output logic              pc_src,
  output logic [ADDR_W-1:0] pc_jumpaddr,
  fetch_ctrl_if.master      imem,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [INST_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
`ifdef FETCH_PERF_EN
  output fetch_state_e      state,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_kill_cnt
`else
  output fetch_state_e      state
`endif
);

  fetch_state_e      state_nxt;
  logic              redir_pend;
  logic [ADDR_W-1:0] redir_addr;
  logic              buf_free;
  logic              req;
  logic              ack_v;
  logic              keep;

  // The buffer can only be refilled by an ack, so once req rises it stays high.
  assign buf_free = !if_valid || !id_stall;
  assign req      = ((state == FETCH_FETCH) && buf_free) || (state == FETCH_KILL);
  assign ack_v    = imem.ack && req;
  assign keep     = (state == FETCH_FETCH) && ack_v && !br_taken;

  assign imem.req  = req;
  assign imem.addr = redir_pend ? redir_addr : pc_addr;

  assign pc_stall    = !keep;
  assign pc_src      = (keep && redir_pend) ? PC_JUMP : PC_INCRESE;
  assign pc_jumpaddr = redir_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_IDLE:  state_nxt = FETCH_FETCH;
      FETCH_FETCH: if (br_taken && req && !ack_v) state_nxt = FETCH_KILL;
      FETCH_KILL:  if (!br_taken && ack_v) state_nxt = FETCH_FETCH;
      default:     state_nxt = FETCH_IDLE;
    endcase
  end

  // The latest redirect target wins until a kept fetch of it consumes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      redir_pend <= 1'b0;
      redir_addr <= '0;
    end else if (br_taken) begin
      redir_pend <= 1'b1;
      redir_addr <= br_target;
    end else if (keep) begin
      redir_pend <= 1'b0;
    end
  end

  fetch_ctrl_if_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_if_buf (
    .clk      (clk),
    .rst      (rst),
    .write    (keep),
    .consume  (if_valid && !id_stall),
    .flush    (br_taken),
    .wr_instr (imem.rdata),
    .wr_pc    (imem.addr),
    .valid    (if_valid),
    .instr    (if_instr),
    .pc       (if_pc)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      if (keep)           perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (ack_v && !keep) perf_kill_cnt  <= perf_kill_cnt + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: prog_count and imem models, directed scenarios and a
// random run checked against the architectural instruction stream.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int AW = 32;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] pc_addr;
  logic pc_stall, pc_src;
  logic [AW-1:0] pc_jumpaddr;
  logic br_taken;
  logic [AW-1:0] br_target;
  logic id_stall;
  logic if_valid;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  fetch_state_e state;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_kill_cnt;
`endif

  fetch_ctrl_if #(.ADDR_W(AW), .INST_W(IW)) imem ();

  fetch_ctrl #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_stall(pc_stall), .pc_src(pc_src),
    .pc_jumpaddr(pc_jumpaddr), .imem(imem), .br_taken(br_taken), .br_target(br_target),
    .id_stall(id_stall), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
`ifdef FETCH_PERF_EN
    .state(state), .perf_fetch_cnt(perf_fetch_cnt), .perf_kill_cnt(perf_kill_cnt)
`else
    .state(state)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, exp finish");
    $fatal(1);
  end

  // ---------------- environment state ----------------
  int total, bad;
  logic [31:0] pc;
  bit mem_busy, mem_br, ack_force;
  int mem_wait, lat_cfg;
  logic [31:0] mem_a;

  logic s_req, s_ack, s_stall, s_src, s_valid, s_chk_stable, s_inflight;
  logic [31:0] s_addr, s_ja, s_pc, s_instr, s_maddr;
  fetch_state_e s_state;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // One clock: drive inputs, answer from memory model, sample, advance models.
  task automatic tick(input logic br, input logic [31:0] tgt, input logic stall);
    br_taken = br; br_target = tgt; id_stall = stall;
    imem.ack = 1'b0; imem.rdata = '0;
    s_chk_stable = 1'b0;
    s_inflight = mem_busy && !rst;
    #1;
    if (ack_force) begin
      imem.ack = 1'b1; imem.rdata = inst_of(imem.addr);
    end else if (imem.req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1; mem_br = 1'b0; mem_a = imem.addr;
        mem_wait = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end else begin
        s_chk_stable = !mem_br;
      end
      imem.ack = (mem_wait == 0);
      imem.rdata = imem.ack ? inst_of(mem_a) : '0;
    end
    #1;
    s_req = imem.req; s_addr = imem.addr; s_ack = imem.ack; s_stall = pc_stall;
    s_src = pc_src; s_ja = pc_jumpaddr; s_valid = if_valid; s_pc = if_pc;
    s_instr = if_instr; s_state = state; s_maddr = mem_a;
    @(posedge clk);
    if (rst) begin
      pc = PC_INIT; mem_busy = 1'b0;
    end else begin
      if (!s_stall) pc = ((s_src == PC_JUMP) ? s_ja : pc) + 32'd4;
      if (mem_busy) begin
        if (br) mem_br = 1'b1;
        if (s_ack) mem_busy = 1'b0; else mem_wait--;
      end
    end
    #1;
    pc_addr = pc;
  endtask

  task automatic do_reset();
    rst = 1'b1; ack_force = 1'b0; lat_cfg = 0;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; ack_force = 1'b0; lat_cfg = 0;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    total++; if (s_state !== FETCH_IDLE) begin bad++; $display("FAIL reset_state: got %0d exp %0d", s_state, FETCH_IDLE); end
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", s_valid); end
    total++; if (s_pc !== 32'h0) begin bad++; $display("FAIL reset_if_pc: got %h exp 0", s_pc); end
    total++; if (s_instr !== 32'h0) begin bad++; $display("FAIL reset_if_instr: got %h exp 0", s_instr); end
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b exp 0", s_req); end
    total++; if (s_stall !== 1'b1) begin bad++; $display("FAIL reset_pc_stall: got %b exp 1", s_stall); end
`ifdef FETCH_PERF_EN
    total++; if (perf_fetch_cnt !== 32'd0 || perf_kill_cnt !== 32'd0) begin bad++; $display("FAIL reset_perf: got %0d/%0d exp 0/0", perf_fetch_cnt, perf_kill_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    do_reset(); ack_force = 1'b1; exp_q.delete();
    tick(1'b0, '0, 1'b0);
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL seq_idle_req: got %b exp 0", s_req); end
    total++; if (s_stall !== 1'b1) begin bad++; $display("FAIL seq_idle_stall: got %b exp 1", s_stall); end
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, '0, 1'b0);
      total++; if (s_req !== 1'b1 || s_addr !== 32'(4 * k)) begin bad++; $display("FAIL seq_addr: got req=%b addr=%h exp req=1 addr=%h", s_req, s_addr, 32'(4 * k)); end
      total++; if (s_stall !== 1'b0 || s_src !== PC_INCRESE) begin bad++; $display("FAIL seq_pc_ctrl: got stall=%b src=%b exp 0/%b", s_stall, s_src, PC_INCRESE); end
      if (k == 0) begin
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL seq_idle_ack_ignored: got valid=%b exp 0", s_valid); end
      end else begin
        e = exp_q.pop_front();
        total++; if (s_valid !== 1'b1 || s_pc !== e || s_instr !== inst_of(e)) begin bad++; $display("FAIL seq_if_pc: got v=%b pc=%h instr=%h exp 1/%h/%h", s_valid, s_pc, s_instr, e, inst_of(e)); end
      end
      exp_q.push_back(32'(4 * k));
    end
    ack_force = 1'b0;
  endtask

  task automatic test_id_stall();
    do_reset(); ack_force = 1'b1;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, '0, 1'b1);
      total++; if (s_req !== 1'b0 || s_stall !== 1'b1) begin bad++; $display("FAIL stall_hold: got req=%b pc_stall=%b exp 0/1", s_req, s_stall); end
      total++; if (s_valid !== 1'b1 || s_pc !== 32'h4 || s_instr !== inst_of(32'h4)) begin bad++; $display("FAIL stall_buf: got v=%b pc=%h instr=%h exp 1/4/%h", s_valid, s_pc, s_instr, inst_of(32'h4)); end
    end
    tick(1'b0, '0, 1'b0);
    total++; if (s_req !== 1'b1 || s_addr !== 32'h8) begin bad++; $display("FAIL stall_resume: got req=%b addr=%h exp 1/8", s_req, s_addr); end
    ack_force = 1'b0;
  endtask

  task automatic test_kill();
    do_reset(); lat_cfg = 4;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b1, 32'h100, 1'b0);
    total++; if (s_req !== 1'b1 || s_stall !== 1'b1) begin bad++; $display("FAIL kill_br_cycle: got req=%b stall=%b exp 1/1", s_req, s_stall); end
    lat_cfg = 0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, '0, 1'b0);
      total++; if (s_state !== FETCH_KILL || s_req !== 1'b1 || s_valid !== 1'b0 || s_stall !== 1'b1) begin bad++; $display("FAIL kill_hold: got st=%0d req=%b v=%b stall=%b exp %0d/1/0/1", s_state, s_req, s_valid, s_stall, FETCH_KILL); end
    end
    tick(1'b0, '0, 1'b0);
    total++; if (s_state !== FETCH_FETCH || s_addr !== 32'h100 || s_valid !== 1'b0) begin bad++; $display("FAIL kill_refetch: got st=%0d addr=%h v=%b exp %0d/100/0", s_state, s_addr, s_valid, FETCH_FETCH); end
    total++; if (s_stall !== 1'b0 || s_src !== PC_JUMP || s_ja !== 32'h100) begin bad++; $display("FAIL kill_jump: got stall=%b src=%b ja=%h exp 0/%b/100", s_stall, s_src, s_ja, PC_JUMP); end
`ifdef FETCH_PERF_EN
    total++; if (perf_fetch_cnt !== 32'd1 || perf_kill_cnt !== 32'd1) begin bad++; $display("FAIL kill_perf: got %0d/%0d exp 1/1", perf_fetch_cnt, perf_kill_cnt); end
`endif
    tick(1'b0, '0, 1'b0);
    total++; if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_addr !== 32'h104) begin bad++; $display("FAIL kill_after: got v=%b pc=%h addr=%h exp 1/100/104", s_valid, s_pc, s_addr); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'b0, '0, 1'b0);
    tick(1'b1, 32'h200, 1'b0);
    total++; if (s_addr !== 32'h10 || s_stall !== 1'b1) begin bad++; $display("FAIL same_br: got addr=%h stall=%b exp 10/1", s_addr, s_stall); end
    tick(1'b0, '0, 1'b0);
    total++; if (s_valid !== 1'b0 || s_state !== FETCH_FETCH || s_addr !== 32'h200) begin bad++; $display("FAIL same_drop: got v=%b st=%0d addr=%h exp 0/%0d/200", s_valid, s_state, s_addr, FETCH_FETCH); end
    total++; if (s_stall !== 1'b0 || s_src !== PC_JUMP || s_ja !== 32'h200) begin bad++; $display("FAIL same_jump: got stall=%b src=%b ja=%h exp 0/%b/200", s_stall, s_src, s_ja, PC_JUMP); end
    tick(1'b0, '0, 1'b0);
    total++; if (s_valid !== 1'b1 || s_pc !== 32'h200 || s_addr !== 32'h204) begin bad++; $display("FAIL same_next: got v=%b pc=%h addr=%h exp 1/200/204", s_valid, s_pc, s_addr); end
    tick(1'b0, '0, 1'b0);
    total++; if (s_pc !== 32'h204) begin bad++; $display("FAIL same_seq: got pc=%h exp 204", s_pc); end
  endtask

  task automatic test_double_kill();
    do_reset(); lat_cfg = 4;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b1, 32'h300, 1'b0);
    tick(1'b1, 32'h400, 1'b0);
    total++; if (s_state !== FETCH_KILL) begin bad++; $display("FAIL dkill_state: got %0d exp %0d", s_state, FETCH_KILL); end
    lat_cfg = 0;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    total++; if (s_addr !== 32'h400 || s_src !== PC_JUMP || s_ja !== 32'h400) begin bad++; $display("FAIL dkill_target: got addr=%h src=%b ja=%h exp 400/%b/400", s_addr, s_src, s_ja, PC_JUMP); end
    tick(1'b0, '0, 1'b0);
    total++; if (s_valid !== 1'b1 || s_pc !== 32'h400) begin bad++; $display("FAIL dkill_buf: got v=%b pc=%h exp 1/400", s_valid, s_pc); end
  endtask

  task automatic test_rst_mid();
    do_reset(); lat_cfg = 4;
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    total++; if (s_req !== 1'b1) begin bad++; $display("FAIL rmid_req_before: got %b exp 1", s_req); end
    rst = 1'b1;
    tick(1'b0, '0, 1'b0);
    rst = 1'b0; lat_cfg = 0;
`ifdef FETCH_PERF_EN
    total++; if (perf_fetch_cnt !== 32'd0 || perf_kill_cnt !== 32'd0) begin bad++; $display("FAIL rmid_perf: got %0d/%0d exp 0/0", perf_fetch_cnt, perf_kill_cnt); end
`endif
    tick(1'b0, '0, 1'b0);
    total++; if (s_state !== FETCH_IDLE || s_req !== 1'b0 || s_valid !== 1'b0) begin bad++; $display("FAIL rmid_idle: got st=%0d req=%b v=%b exp %0d/0/0", s_state, s_req, s_valid, FETCH_IDLE); end
    tick(1'b0, '0, 1'b0);
    total++; if (s_req !== 1'b1 || s_addr !== PC_INIT) begin bad++; $display("FAIL rmid_restart: got req=%b addr=%h exp 1/%h", s_req, s_addr, PC_INIT); end
  endtask

  // Decode must see the program order: +4 steps, restarting at each redirect target.
  task automatic test_random();
    logic br, stall;
    logic [31:0] tgt, arch_next;
    int consumed;
    do_reset(); lat_cfg = -1;
    arch_next = PC_INIT; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      br = ($urandom_range(0, 11) == 0);
      tgt = 32'($urandom_range(0, 1023)) * 32'd4;
      stall = ($urandom_range(0, 3) == 0);
      tick(br, tgt, stall);
      if (s_valid && !stall && !br) begin
        total++; if (s_pc !== arch_next || s_instr !== inst_of(arch_next)) begin bad++; $display("FAIL rand_stream: got pc=%h instr=%h exp %h/%h", s_pc, s_instr, arch_next, inst_of(arch_next)); end
        arch_next += 32'd4; consumed++;
      end
      if (br) arch_next = tgt;
      if (s_inflight) begin
        total++; if (s_req !== 1'b1) begin bad++; $display("FAIL rand_req_drop: got req=%b exp 1", s_req); end
      end
      if (s_chk_stable) begin
        total++; if (s_addr !== s_maddr) begin bad++; $display("FAIL rand_addr_stable: got %h exp %h", s_addr, s_maddr); end
      end
    end
    total++; if (consumed < 200) begin bad++; $display("FAIL rand_progress: got %0d exp >=200", consumed); end
  endtask

  initial begin
    total = 0; bad = 0;
    pc = PC_INIT; pc_addr = PC_INIT;
    mem_busy = 1'b0; mem_br = 1'b0; mem_wait = 0; mem_a = '0;
    lat_cfg = 0; ack_force = 1'b0;
    imem.ack = 1'b0; imem.rdata = '0;
    br_taken = 1'b0; br_target = '0; id_stall = 1'b0;
    test_reset();
    test_sequential();
    test_id_stall();
    test_kill();
    test_same_cycle();
    test_double_kill();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
